// File: rtl/key_pkg.sv
// Shared types and default timing constants for the pushbutton debouncer.
package key_pkg;

   // Default timing: 1 ms sample tick at 50 MHz, 20 ms debounce, 1 s long press
   localparam int unsigned NUM_KEYS_DEF       = 4;
   localparam int unsigned TICK_DIV_DEF       = 50000;
   localparam int unsigned DEBOUNCE_TICKS_DEF = 20;
   localparam int unsigned LONG_TICKS_DEF     = 1000;

   // Per-channel debounce FSM state
   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_HELD         = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } key_fsm_e;

   // Everything one channel reports to the top
   typedef struct packed {
      logic level;   // debounced level, 1 = pressed
      logic press;   // one-cycle accepted-press pulse
      logic rel;     // one-cycle accepted-release pulse
      logic lng;     // one-cycle long-press pulse
   } key_evt_t;

   // Counter width able to hold 0..limit inclusive
   function automatic int unsigned cnt_width(input int unsigned limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One pushbutton channel: debounce FSM, stability and long-press counters,
// registered level and event pulses.
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
   parameter int unsigned LONG_TICKS     = LONG_TICKS_DEF
) (
   input  logic     mclk,
   input  logic     rst_n,
   input  logic     ks_i,     // synchronised key, 1 = pressed
   input  logic     tick_i,   // shared sample tick
   output key_evt_t evt_o
);

   localparam int unsigned DEB_W  = cnt_width(DEBOUNCE_TICKS);
   localparam int unsigned LONG_W = cnt_width(LONG_TICKS);

   key_fsm_e          state_q, state_d;
   logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
   logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
   logic              level_q, level_d;
   logic              press_q, press_d;
   logic              rel_q, rel_d;
   logic              lng_q, lng_d;

   logic deb_last_c;    // this tick completes the stability window
   logic long_sat_c;    // long press already reached (and fired)

   assign deb_last_c = (deb_cnt_q == DEB_W'(DEBOUNCE_TICKS - 1));
   assign long_sat_c = (long_cnt_q == LONG_W'(LONG_TICKS));

   // State, counter and output registers
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         deb_cnt_q  <= '0;
         long_cnt_q <= '0;
         level_q    <= 1'b0;
         press_q    <= 1'b0;
         rel_q      <= 1'b0;
         lng_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         deb_cnt_q  <= deb_cnt_d;
         long_cnt_q <= long_cnt_d;
         level_q    <= level_d;
         press_q    <= press_d;
         rel_q      <= rel_d;
         lng_q      <= lng_d;
      end
   end

   // Next-state, counter and pulse logic
   always_comb begin
      state_d    = state_q;
      deb_cnt_d  = deb_cnt_q;
      long_cnt_d = long_cnt_q;
      level_d    = level_q;
      press_d    = 1'b0;
      rel_d      = 1'b0;
      lng_d      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (ks_i) begin
               state_d   = ST_PRESS_WAIT;
               deb_cnt_d = '0;
            end
         end

         ST_PRESS_WAIT: begin
            if (!ks_i) begin
               // bounce: drop back silently
               state_d = ST_IDLE;
            end else if (tick_i) begin
               deb_cnt_d = deb_cnt_q + DEB_W'(1);
               if (deb_last_c) begin
                  state_d    = ST_HELD;
                  level_d    = 1'b1;
                  press_d    = 1'b1;
                  long_cnt_d = '0;
               end
            end
         end

         ST_HELD: begin
            // long counter saturates, so the long pulse fires once per press
            if (tick_i && !long_sat_c) begin
               long_cnt_d = long_cnt_q + LONG_W'(1);
               if (long_cnt_q == LONG_W'(LONG_TICKS - 1)) begin
                  lng_d = 1'b1;
               end
            end
            if (!ks_i) begin
               state_d   = ST_RELEASE_WAIT;
               deb_cnt_d = '0;
            end
         end

         ST_RELEASE_WAIT: begin
            if (ks_i) begin
               // glitch during hold: resume, keeping long-press progress
               state_d = ST_HELD;
            end else if (tick_i) begin
               deb_cnt_d = deb_cnt_q + DEB_W'(1);
               if (deb_last_c) begin
                  state_d = ST_IDLE;
                  level_d = 1'b0;
                  rel_d   = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign evt_o.level = level_q;
   assign evt_o.press = press_q;
   assign evt_o.rel   = rel_q;
   assign evt_o.lng   = lng_q;

endmodule

// File: rtl/key_debounce.sv
// Pushbutton front end: synchronises active-low key pins, generates the
// shared sample tick and runs one debounce channel per key.
module key_debounce
   import key_pkg::*;
#(
   parameter int unsigned NUM_KEYS       = NUM_KEYS_DEF,
   parameter int unsigned TICK_DIV       = TICK_DIV_DEF,
   parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
   parameter int unsigned LONG_TICKS     = LONG_TICKS_DEF
) (
   input  logic                mclk,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic [NUM_KEYS-1:0] key_state,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_long
);

   localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [NUM_KEYS-1:0] sync1_q, sync2_q;
   logic [NUM_KEYS-1:0] ks_c;
   logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
   logic                tick_q, tick_d;
   key_evt_t            evt [NUM_KEYS];

   // Two-flop synchroniser; resets to the released (high) pin level
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= key_n;
         sync2_q <= sync1_q;
      end
   end

   assign ks_c = ~sync2_q;

   // Tick divider next-state: tick is high in the cycle the counter sits at 0 after a wrap
   always_comb begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
      tick_d     = 1'b0;
      if (tick_cnt_q == TICK_W'(TICK_DIV - 1)) begin
         tick_cnt_d = '0;
         tick_d     = 1'b1;
      end
   end

   // Tick divider registers
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt_q <= '0;
         tick_q     <= 1'b0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         tick_q     <= tick_d;
      end
   end

   // Independent channel per key
   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
      key_debounce_ch #(
         .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
         .LONG_TICKS     (LONG_TICKS)
      ) u_ch (
         .mclk   (mclk),
         .rst_n  (rst_n),
         .ks_i   (ks_c[g]),
         .tick_i (tick_q),
         .evt_o  (evt[g])
      );

      assign key_state[g]   = evt[g].level;
      assign key_press[g]   = evt[g].press;
      assign key_release[g] = evt[g].rel;
      assign key_long[g]    = evt[g].lng;
   end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed key stimulus, expected pulses queued with
// cycle windows, a negedge monitor pops and compares each observed pulse.
module tb_key_debounce;

   localparam int unsigned NK = 4;
   localparam int K_PRESS = 0;
   localparam int K_REL   = 1;
   localparam int K_LONG  = 2;

   logic          mclk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NK-1:0] key_n = '1;
   logic [NK-1:0] key_state, key_press, key_release, key_long;

   typedef struct {
      int       kind;
      logic [3:0] mask;
      int       lo;
      int       hi;
   } exp_t;

   exp_t       sb [$];
   exp_t       mon_e;
   logic [3:0] mon_pm [3];
   int         cyc = 0;
   int         vectors = 0;
   int         miscompares = 0;
   bit         done = 1'b0;
   int         e0, r0;

   key_debounce #(
      .NUM_KEYS       (NK),
      .TICK_DIV       (4),
      .DEBOUNCE_TICKS (3),
      .LONG_TICKS     (10)
   ) dut (
      .mclk        (mclk),
      .rst_n       (rst_n),
      .key_n       (key_n),
      .key_state   (key_state),
      .key_press   (key_press),
      .key_release (key_release),
      .key_long    (key_long)
   );

   always #5 mclk = ~mclk;

   always @(posedge mclk) cyc <= cyc + 1;

   function automatic string kname(input int k);
      case (k)
         K_PRESS: return "press";
         K_REL:   return "release";
         default: return "long";
      endcase
   endfunction

   function automatic void push_exp(input int kind, input logic [3:0] mask,
                                    input int lo, input int hi);
      exp_t e;
      e.kind = kind;
      e.mask = mask;
      e.lo   = lo;
      e.hi   = hi;
      sb.push_back(e);
   endfunction

   // Monitor: every observed pulse must match the oldest expectation
   always @(negedge mclk) begin
      if (rst_n && !done) begin
         mon_pm[K_PRESS] = key_press;
         mon_pm[K_REL]   = key_release;
         mon_pm[K_LONG]  = key_long;
         for (int k = 0; k < 3; k++) begin
            if (mon_pm[k] != 4'b0) begin
               vectors++;
               if (sb.size() == 0) begin
                  miscompares++;
                  $display("FAIL unexpected_%s: got mask=%b at cycle %0d, required no pulse",
                           kname(k), mon_pm[k], cyc);
               end else begin
                  mon_e = sb.pop_front();
                  if (mon_e.kind != k || mon_e.mask != mon_pm[k] ||
                      cyc < mon_e.lo || cyc > mon_e.hi) begin
                     miscompares++;
                     $display("FAIL pulse_%s: got %s mask=%b at cycle %0d, required %s mask=%b in cycles %0d..%0d",
                              kname(mon_e.kind), kname(k), mon_pm[k], cyc,
                              kname(mon_e.kind), mon_e.mask, mon_e.lo, mon_e.hi);
                  end
               end
            end
         end
         if (sb.size() != 0 && cyc > sb[0].hi) begin
            vectors++;
            miscompares++;
            $display("FAIL missing_%s: got no pulse by cycle %0d, required mask=%b in cycles %0d..%0d",
                     kname(sb[0].kind), cyc, sb[0].mask, sb[0].lo, sb[0].hi);
            void'(sb.pop_front());
         end
      end
   end

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %b, required %b", name, act, req);
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge mclk);
         #1;
      end
   endtask

   // Wait (bounded) until the monitor has consumed every expectation
   task automatic drain(input int maxc);
      int k = 0;
      while (sb.size() != 0 && k < maxc) begin
         @(posedge mclk);
         k++;
      end
      #1;
      if (sb.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: got %0d pending events, required 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, required $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      key_n = '1;
      repeat (3) @(posedge mclk);
      #1;
      chk("reset_state", key_state, 4'b0000);
      chk("reset_pulses", key_press | key_release | key_long, 4'b0000);
      rst_n = 1'b1;
      wait_until(cyc + 10);

      // 1: single press on key 0
      e0 = cyc;
      key_n[0] = 1'b0;
      push_exp(K_PRESS, 4'b0001, e0 + 10, e0 + 18);
      drain(60);
      @(negedge mclk);
      chk("t1_state", key_state, 4'b0001);
      @(posedge mclk); #1;
      e0 = cyc;
      key_n[0] = 1'b1;
      push_exp(K_REL, 4'b0001, e0 + 10, e0 + 18);
      drain(60);
      @(negedge mclk);
      chk("t1_released", key_state, 4'b0000);
      @(posedge mclk); #1;

      // 2: key 1 bouncing every 3 cycles never accepted
      for (int i = 0; i < 40; i++) begin
         if (i % 3 == 0) key_n[1] = ~key_n[1];
         @(negedge mclk);
         chk("t2_bounce_state", key_state, 4'b0000);
         @(posedge mclk); #1;
      end
      key_n[1] = 1'b1;
      wait_until(cyc + 20);
      @(negedge mclk);
      chk("t2_final_state", key_state, 4'b0000);
      @(posedge mclk); #1;

      // 3: key 2 held 60 cycles: press, one long, then release
      e0 = cyc;
      key_n[2] = 1'b0;
      push_exp(K_PRESS, 4'b0100, e0 + 10, e0 + 18);
      push_exp(K_LONG,  4'b0100, e0 + 46, e0 + 60);
      wait_until(e0 + 20);
      @(negedge mclk);
      chk("t3_held", key_state, 4'b0100);
      wait_until(e0 + 60);
      r0 = cyc;
      key_n[2] = 1'b1;
      push_exp(K_REL, 4'b0100, r0 + 10, r0 + 18);
      drain(60);
      @(negedge mclk);
      chk("t3_released", key_state, 4'b0000);
      @(posedge mclk); #1;

      // 4: one-tick glitch while held after the long press
      e0 = cyc;
      key_n[2] = 1'b0;
      push_exp(K_PRESS, 4'b0100, e0 + 10, e0 + 18);
      push_exp(K_LONG,  4'b0100, e0 + 46, e0 + 60);
      wait_until(e0 + 62);
      key_n[2] = 1'b1;
      wait_until(e0 + 66);
      key_n[2] = 1'b0;
      wait_until(e0 + 80);
      @(negedge mclk);
      chk("t4_after_glitch", key_state, 4'b0100);
      wait_until(e0 + 100);
      r0 = cyc;
      key_n[2] = 1'b1;
      push_exp(K_REL, 4'b0100, r0 + 10, r0 + 18);
      drain(60);
      @(negedge mclk);
      chk("t4_released", key_state, 4'b0000);
      @(posedge mclk); #1;

      // 5: keys 0 and 3 pressed together
      e0 = cyc;
      key_n[0] = 1'b0;
      key_n[3] = 1'b0;
      push_exp(K_PRESS, 4'b1001, e0 + 10, e0 + 18);
      drain(60);
      @(negedge mclk);
      chk("t5_state", key_state, 4'b1001);
      @(posedge mclk); #1;
      e0 = cyc;
      key_n[0] = 1'b1;
      key_n[3] = 1'b1;
      push_exp(K_REL, 4'b1001, e0 + 10, e0 + 18);
      drain(60);
      @(negedge mclk);
      chk("t5_released", key_state, 4'b0000);
      @(posedge mclk); #1;

      // 6: reset while key 1 is held, then fresh press after reset
      e0 = cyc;
      key_n[1] = 1'b0;
      push_exp(K_PRESS, 4'b0010, e0 + 10, e0 + 18);
      drain(60);
      chk("t6_held", key_state, 4'b0010);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_state", key_state, 4'b0000);
      chk("t6_rst_pulses", key_press | key_release | key_long, 4'b0000);
      repeat (3) @(posedge mclk);
      #1;
      e0 = cyc;
      rst_n = 1'b1;
      push_exp(K_PRESS, 4'b0010, e0 + 10, e0 + 18);
      drain(60);
      @(negedge mclk);
      chk("t6_repress_state", key_state, 4'b0010);
      @(posedge mclk); #1;
      e0 = cyc;
      key_n[1] = 1'b1;
      push_exp(K_REL, 4'b0010, e0 + 10, e0 + 18);
      drain(60);
      @(negedge mclk);
      chk("t6_released", key_state, 4'b0000);

      // quiet tail: any stray pulse is flagged by the monitor
      repeat (30) @(posedge mclk);
      #1;
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_empty: got %0d pending, required 0", sb.size());
      end
      done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
